// File: rtl/adc_window_capture.sv
// adc_window_capture: accumulates ADC samples over each adc_en window and queues
// one tagged record per window in a first-word-fall-through FIFO.
module adc_window_capture #(
  parameter int DATA_W      = 12,
  parameter int MAX_SAMPLES = 255,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          fpga_clk,
  input  logic                          rst_n,
  input  logic                          sys_init_ctrl,
  input  logic                          adc_en,
  input  logic [3:0]                    rf_sw,
  input  logic [9:0]                    rot_count,
  input  logic [DATA_W-1:0]             adc_data,
  input  logic                          adc_valid,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [1:0]                    rec_chan,
  output logic [9:0]                    rec_rot,
  output logic [DATA_W+7:0]             rec_sum,
  output logic [7:0]                    rec_cnt,
  output logic                          rec_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = DATA_W + 8;
  localparam int RW = 2 + 10 + SW + 8 + 1;
  typedef enum logic [1:0] {IDLE, ACQ, PUSH} state_t;
  state_t          r_state, w_next;
  logic            r_adc_en_q;
  logic [1:0]      r_chan;
  logic [9:0]      r_rot;
  logic [SW-1:0]   r_sum;
  logic [7:0]      r_cnt;
  logic            r_err;
  logic [RW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_level;
  logic            r_ovf;
  logic            w_open, w_take, w_bad, w_full, w_pop, w_push;
  logic [1:0]      w_chan;
  logic [RW-1:0]   w_head;
  always_comb begin
    w_chan = rf_sw == 4'b0010 ? 2'd1 : rf_sw == 4'b0100 ? 2'd2 : rf_sw == 4'b1000 ? 2'd3 : 2'd0;
    w_bad  = !$onehot(rf_sw);
    // a rise seen in PUSH opens the next window back-to-back
    w_open = adc_en & !r_adc_en_q & (r_state != ACQ);
    w_take = (r_state == ACQ) & adc_en & adc_valid;
    w_next = w_open ? ACQ : r_state == ACQ ? (adc_en ? ACQ : PUSH) : IDLE;
    rec_valid  = r_level != '0;
    w_full     = r_level == (AW+1)'(FIFO_DEPTH);
    w_pop      = rec_valid & rec_ready & !sys_init_ctrl;
    w_push     = (r_state == PUSH) & (!w_full | w_pop) & !sys_init_ctrl;
    w_head     = r_mem[r_rptr];
    {rec_chan, rec_rot, rec_sum, rec_cnt, rec_err} = rec_valid ? w_head : '0;
    fifo_level = r_level;
    ovf        = r_ovf;
  end
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_adc_en_q <= 1'b0;
      r_chan     <= '0;
      r_rot      <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_adc_en_q <= adc_en;
      r_state    <= sys_init_ctrl ? IDLE : w_next;
      if (w_open) begin
        r_chan <= w_chan;
        r_err  <= w_bad;
        r_rot  <= rot_count;
        r_sum  <= adc_valid ? SW'(adc_data) : '0;
        r_cnt  <= {7'd0, adc_valid};
      end else if (w_take) begin
        if (r_cnt < 8'(MAX_SAMPLES)) begin
          r_sum <= r_sum + SW'(adc_data);
          r_cnt <= r_cnt + 8'd1;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (sys_init_ctrl) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        if ((r_state == PUSH) & w_full & !w_pop) r_ovf <= 1'b1;
      end
    end
  end
  always_ff @(posedge fpga_clk) begin
    if (w_push) r_mem[r_wptr] <= {r_chan, r_rot, r_sum, r_cnt, r_err};
  end
endmodule

// File: tb/tb_adc_window_capture.sv
// tb_adc_window_capture: randomized windows checked against a queue-based record model.
module tb_adc_window_capture;
  logic        fpga_clk = 0, rst_n = 0, sys_init_ctrl = 0, adc_en = 0, adc_valid = 0, rec_ready = 0;
  logic [3:0]  rf_sw = 0;
  logic [9:0]  rot_count = 0;
  logic [11:0] adc_data = 0;
  logic        rec_valid, rec_err, ovf;
  logic [1:0]  rec_chan;
  logic [9:0]  rec_rot;
  logic [19:0] rec_sum;
  logic [7:0]  rec_cnt;
  logic [2:0]  fifo_level;
  typedef struct {logic [1:0] chan; logic [9:0] rot; logic [19:0] sum; logic [7:0] cnt; logic err;} rec_t;
  rec_t q[$];
  bit   m_ovf = 0;
  int   n_cmp = 0, n_bad = 0;
  adc_window_capture dut (
    .fpga_clk(fpga_clk), .rst_n(rst_n), .sys_init_ctrl(sys_init_ctrl), .adc_en(adc_en),
    .rf_sw(rf_sw), .rot_count(rot_count), .adc_data(adc_data), .adc_valid(adc_valid),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_chan(rec_chan), .rec_rot(rec_rot),
    .rec_sum(rec_sum), .rec_cnt(rec_cnt), .rec_err(rec_err), .fifo_level(fifo_level), .ovf(ovf)
  );
  always #5 fpga_clk = ~fpga_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge fpga_clk);
      adc_en = 0; adc_valid = 0; rec_ready = 0;
    end
  endtask
  task automatic init_pulse();
    @(negedge fpga_clk); sys_init_ctrl = 1;
    @(negedge fpga_clk); sys_init_ctrl = 0;
    q.delete(); m_ovf = 0;
  endtask
  task automatic window(input logic [3:0] rf, input logic [9:0] rot, input int len,
                        input int vpct, input int fixed, input bit pop_in_push);
    rec_t r;
    int   n = 0;
    r.chan = rf == 4'b0010 ? 2'd1 : rf == 4'b0100 ? 2'd2 : rf == 4'b1000 ? 2'd3 : 2'd0;
    r.rot = rot; r.sum = 0; r.err = ($countones(rf) != 1);
    for (int i = 0; i < len; i++) begin
      @(negedge fpga_clk);
      adc_en    = 1;
      rf_sw     = i == 0 ? rf : 4'($urandom);
      rot_count = i == 0 ? rot : 10'($urandom);
      adc_valid = $urandom_range(99) < vpct;
      adc_data  = fixed >= 0 ? 12'(fixed) : 12'($urandom);
      if (adc_valid) begin
        if (n < 255) begin r.sum += 20'(adc_data); n++; end
        else r.err = 1;
      end
    end
    r.cnt = 8'(n);
    @(negedge fpga_clk);
    adc_en = 0; adc_valid = 1'($urandom); adc_data = 12'($urandom);
    if (pop_in_push) begin
      @(negedge fpga_clk); rec_ready = 1; adc_valid = 0;
      @(negedge fpga_clk); rec_ready = 0;
      void'(q.pop_front());
      q.push_back(r);
    end else if (q.size() < 4) q.push_back(r);
    else m_ovf = 1;
  endtask
  task automatic drain();
    idle(3);
    chk("level", fifo_level, q.size());
    chk("ovf", ovf, m_ovf);
    for (int k = 0; k < 200 && q.size() > 0; k++) begin
      bit rd = $urandom_range(3) != 0;
      chk("valid", rec_valid, 1);
      chk("chan", rec_chan, q[0].chan);
      chk("rot", rec_rot, q[0].rot);
      chk("sum", rec_sum, q[0].sum);
      chk("cnt", rec_cnt, q[0].cnt);
      chk("err", rec_err, q[0].err);
      rec_ready = rd;
      @(negedge fpga_clk);
      if (rd) void'(q.pop_front());
    end
    rec_ready = 0;
    chk("drain_done", q.size(), 0);
    chk("empty", rec_valid, 0);
    chk("level0", fifo_level, 0);
    chk("data0", rec_sum, 0);
  endtask
  initial begin
    #2;
    chk("rst_valid", rec_valid, 0); chk("rst_level", fifo_level, 0); chk("rst_ovf", ovf, 0);
    chk("rst_sum", rec_sum, 0); chk("rst_chan", rec_chan, 0); chk("rst_rot", rec_rot, 0);
    @(negedge fpga_clk); rst_n = 1;
    idle(2);
    window(4'b0010, 10'd5, 30, 100, 100, 0);
    @(negedge fpga_clk); adc_valid = 0;
    chk("lat_1", rec_valid, 0);
    @(negedge fpga_clk);
    chk("lat_2", rec_valid, 1);
    chk("t1_sum", rec_sum, 3000);
    drain();
    window(4'b0100, 10'd77, 300, 100, 4095, 0);
    drain();
    window(4'b0011, 10'd9, 3, 100, 7, 0);
    drain();
    for (int i = 0; i < 5; i++) window(4'b0001 << (i % 4), 10'(100 + i), 2 + i, 70, -1, 0);
    drain();
    init_pulse();
    chk("init_ovf", ovf, 0);
    for (int i = 0; i < 4; i++) window(4'b1000, 10'(200 + i), 4, 100, -1, 0);
    window(4'b0001, 10'd300, 5, 100, -1, 1);
    chk("pp_level", fifo_level, 4);
    chk("pp_ovf", ovf, 0);
    drain();
    init_pulse();
    for (int i = 0; i < 2; i++) window(4'b0010, 10'(400 + i), 3, 100, -1, 0);
    idle(3);
    chk("pre_init_level", fifo_level, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge fpga_clk);
      adc_en = 1; adc_valid = 1; adc_data = 12'($urandom);
      sys_init_ctrl = (i == 4);
    end
    q.delete(); m_ovf = 0;
    idle(5);
    chk("abort_level", fifo_level, 0);
    chk("abort_valid", rec_valid, 0);
    chk("abort_ovf", ovf, 0);
    window(4'b0100, 10'd511, 6, 100, 33, 0);
    drain();
    window(4'b0001, 10'd1, 4, 0, -1, 0);
    drain();
    for (int it = 0; it < 60; it++) begin
      logic [3:0] rf = $urandom_range(4) == 0 ? 4'($urandom) : 4'b0001 << $urandom_range(3);
      window(rf, 10'($urandom), $urandom_range(1, 12), $urandom_range(100), -1, 0);
      idle($urandom_range(2));
      if ($urandom_range(3) == 0) drain();
    end
    drain();
    for (int i = 0; i < 2; i++) window(4'b1000, 10'(600 + i), 3, 100, -1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge fpga_clk); adc_en = 1; adc_valid = 1;
    end
    #2 rst_n = 0;
    #1;
    chk("arst_valid", rec_valid, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_sum", rec_sum, 0);
    q.delete(); m_ovf = 0;
    idle(1); rst_n = 1;
    idle(2);
    window(4'b0010, 10'd42, 8, 100, 5, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adc_window_capture.md
Name: adc_window_capture

Overview:
- Acquisition-side counterpart to the scan sequencer's ADC gating outputs.
- Monitors adc_en windows and accumulates ADC samples arriving during each window.
- Tags each window with the active RF channel (decoded from rf_sw) and the rotation index (rot_count).
- Pushes one record per window into a small first-word-fall-through (FWFT) FIFO, drained by the host/UART side with a valid/ready handshake.

Parameters:
- DATA_W, 12, ADC sample width in bits.
- MAX_SAMPLES, 255, maximum samples accumulated per window (must be ≤ 255).
- FIFO_DEPTH, 4, record FIFO depth (power of 2, ≥ 2).

Ports:
- fpga_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sys_init_ctrl  in  1  synchronous system init: abort window, flush FIFO, clear sticky flags.
- adc_en  in  1  acquisition window gate from the sequencer.
- rf_sw  in  4  one-hot RF switch select from the sequencer.
- rot_count  in  10  rotation index from the sequencer.
- adc_data  in  DATA_W  ADC sample, unsigned.
- adc_valid  in  1  one-cycle strobe: adc_data is valid.
- rec_valid  out  1  FIFO head record is valid.
- rec_ready  in  1  consumer accepts the head record.
- rec_chan  out  2  channel index of the head record.
- rec_rot  out  10  rot_count latched at window open.
- rec_sum  out  DATA_W+8  sum of accepted samples.
- rec_cnt  out  8  number of accepted samples.
- rec_err  out  1  head record flag: bad rf_sw code or sample saturation.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  records currently held.
- ovf  out  1  sticky: a record was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE; FIFO empty.
  - rec_valid=0, ovf=0, fifo_level=0; rec_* data outputs = 0.
  - adc_en_q=0.
- adc_en_q is the registered copy of adc_en.
  - Rise: adc_en=1 and adc_en_q=0.
  - Fall: adc_en=0 while in ACQ.
- FSM states: IDLE, ACQ, PUSH.
  - IDLE --rise--> ACQ.
  - In the rise cycle:
    - Latch rot_count.
    - Decode rf_sw: 0001→0, 0010→1, 0100→2, 1000→3. Any other code → chan=0, err=1.
    - sum = adc_valid ? adc_data : 0; cnt = adc_valid ? 1 : 0.
  - ACQ: each cycle with adc_en=1 and adc_valid=1:
    - If cnt < MAX_SAMPLES: sum += adc_data, cnt += 1.
    - Otherwise: sample discarded, err=1.
  - ACQ --adc_en=0--> PUSH. A sample strobed in that same cycle is ignored.
  - PUSH (exactly 1 cycle): write {chan, rot, sum, cnt, err} into the FIFO.
    - If the FIFO is full and no pop occurs this cycle: record dropped, ovf<=1.
    - Next state: ACQ if adc_en=1 (rise handling applied), else IDLE.
- Window-to-record latency: the record appears at the FIFO head (rec_valid=1) 2 cycles after the first adc_en=0 cycle, when the FIFO was empty.
- A window of zero samples still produces a record with cnt=0, sum=0.
- sum width is DATA_W+8, so accumulation cannot overflow.
- FIFO:
  - FWFT: rec_valid = !empty; rec_* show the head entry.
  - Pop occurs when rec_valid & rec_ready.
  - Push and pop in the same cycle: both occur; level unchanged; push accepted even when full.
  - rec_ready while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- sys_init_ctrl=1 (priority over all other events):
  - Next state IDLE; partial window discarded with no record.
  - FIFO flushed; ovf cleared.
  - adc_en_q still updates, so a window already open when init deasserts is not detected until the next rise.
- rst_n asserted mid-window or mid-PUSH: immediate return to the reset state.
- rot_count and rf_sw are sampled only at window open; changes during the window are ignored.

Test Plan:
1. rf_sw=0010, rot_count=5; adc_en high 30 cycles with adc_valid every cycle, adc_data=100 → one record: chan=1, rot=5, sum=3000, cnt=30, err=0; rec_valid 2 cycles after adc_en falls.
2. MAX_SAMPLES=255; window of 300 valid samples of 4095 → cnt=255, sum=1044225, err=1.
3. rf_sw=0011 at window open, 3 samples of 7 → chan=0, sum=21, cnt=3, err=1.
4. rec_ready=0; 5 windows with FIFO_DEPTH=4 → fifo_level=4, ovf=1, the first 4 records intact in order; then rec_ready=1 → 4 pops in order, rec_valid=0 after.
5. Full FIFO with rec_ready=1 in the PUSH cycle → pop and push both occur, level stays 4, ovf stays 0.
6. sys_init_ctrl pulsed mid-window with 2 records queued → fifo_level=0, ovf=0, no record for the aborted window; the next full window produces a normal record.
